// File: rtl/sfm_stream_sched.sv
// Row scheduler: one load and one store streamer command per tile row, loads bounded to MAX_AHEAD rows ahead of completed stores.
// Latency: busy_o one cycle after start_i; req_start is combinational on ready_start in the ISSUE states; done_o in the cycle of the last store done.
// Backpressure: requests wait on ready_start; loads also stall while MAX_AHEAD rows await their store done; start_i ignored while busy.

// Streamer command/flag types shared with the HCI load/store streamers.
package sfm_hci_pkg;
    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] tot_len;
        logic [31:0] d0_len;
        logic [31:0] d0_stride;
        logic [31:0] d1_len;
        logic [31:0] d1_stride;
        logic [31:0] d2_len;
        logic [31:0] d2_stride;
        logic [31:0] d3_stride;
        logic [2:0]  dim_enable_1h;
    } hci_addressgen_ctrl_t;

    typedef struct packed {
        logic                 req_start;
        hci_addressgen_ctrl_t addressgen_ctrl;
    } hci_streamer_ctrl_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } hci_streamer_flags_t;
endpackage

module sfm_stream_sched
    import sfm_hci_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ROW_W      = 16,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned MAX_AHEAD  = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] in_base_i,
    input  logic [ADDR_WIDTH-1:0] out_base_i,
    input  logic [ADDR_WIDTH-1:0] row_stride_i,
    input  logic [ROW_W-1:0]      rows_i,
    input  logic [LEN_W-1:0]      row_len_i,
    output hci_streamer_ctrl_t    in_ctrl_o,
    input  hci_streamer_flags_t   in_flags_i,
    output hci_streamer_ctrl_t    out_ctrl_o,
    input  hci_streamer_flags_t   out_flags_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ROW_W-1:0]      rows_done_o
);

    // One extra bit so a tile of 2^ROW_W-1 rows never wraps the row counters.
    localparam int unsigned CNT_W = ROW_W + 1;

    typedef enum logic [1:0] {L_IDLE, L_ISSUE, L_WAIT} l_state_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} s_state_e;

    l_state_e l_state_q, l_state_d;
    s_state_e s_state_q, s_state_d;

    logic                  busy_q;
    logic [ROW_W-1:0]      rows_q;
    logic [LEN_W-1:0]      len_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] ld_addr_q;
    logic [ADDR_WIDTH-1:0] st_addr_q;
    logic [CNT_W-1:0]      lr_q;   // loads issued
    logic [CNT_W-1:0]      sr_q;   // stores issued
    logic [CNT_W-1:0]      sd_q;   // stores done

    logic             start_acc;
    logic             ld_issue;
    logic             st_issue;
    logic             st_done;
    logic             last_st;
    logic             zero_done;
    logic             tile_done;
    logic [CNT_W-1:0] rows_ext;
    logic [CNT_W-1:0] ahead;
    logic [CNT_W-1:0] sd_inc;

    // Issue/complete qualifiers; all use the registered counters, so a store done
    // only frees a load slot from the following cycle and a store never issues
    // in the same cycle as its own row's load.
    always_comb begin
        start_acc = start_i & ~busy_q;
        rows_ext  = {1'b0, rows_q};
        ahead     = lr_q - sd_q;
        sd_inc    = sd_q + CNT_W'(1);
        ld_issue  = (l_state_q == L_ISSUE) && in_flags_i.ready_start
                    && (ahead < CNT_W'(MAX_AHEAD));
        st_issue  = (s_state_q == S_ISSUE) && out_flags_i.ready_start && (sr_q < lr_q);
        st_done   = (s_state_q == S_WAIT) && out_flags_i.done;
        last_st   = st_done && (sd_inc == rows_ext);
        zero_done = busy_q && (rows_q == '0);
        tile_done = last_st | zero_done;
    end

    // Load FSM next state; a new tile also pulls the FSM out of a lingering
    // L_WAIT in case the last load's done arrived after the last store's done.
    always_comb begin
        l_state_d = l_state_q;
        if (start_acc) begin
            l_state_d = (rows_i != '0) ? L_ISSUE : L_IDLE;
        end else begin
            case (l_state_q)
                L_IDLE:  l_state_d = L_IDLE;
                L_ISSUE: if (ld_issue) l_state_d = L_WAIT;
                L_WAIT:  if (in_flags_i.done) l_state_d = (lr_q < rows_ext) ? L_ISSUE : L_IDLE;
                default: l_state_d = L_IDLE;
            endcase
        end
    end

    // Store FSM next state; done flags outside S_WAIT are ignored.
    always_comb begin
        s_state_d = s_state_q;
        if (start_acc) begin
            s_state_d = (rows_i != '0) ? S_ISSUE : S_IDLE;
        end else begin
            case (s_state_q)
                S_IDLE:  s_state_d = S_IDLE;
                S_ISSUE: if (st_issue) s_state_d = S_WAIT;
                S_WAIT:  if (st_done) s_state_d = last_st ? S_IDLE : S_ISSUE;
                default: s_state_d = S_IDLE;
            endcase
        end
    end

    // FSM state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            l_state_q <= L_IDLE;
            s_state_q <= S_IDLE;
        end else if (clear_i) begin
            l_state_q <= L_IDLE;
            s_state_q <= S_IDLE;
        end else begin
            l_state_q <= l_state_d;
            s_state_q <= s_state_d;
        end
    end

    // Tile configuration, address generators and row counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q    <= 1'b0;
            rows_q    <= '0;
            len_q     <= '0;
            stride_q  <= '0;
            ld_addr_q <= '0;
            st_addr_q <= '0;
            lr_q      <= '0;
            sr_q      <= '0;
            sd_q      <= '0;
        end else if (clear_i) begin
            busy_q    <= 1'b0;
            rows_q    <= '0;
            len_q     <= '0;
            stride_q  <= '0;
            ld_addr_q <= '0;
            st_addr_q <= '0;
            lr_q      <= '0;
            sr_q      <= '0;
            sd_q      <= '0;
        end else if (start_acc) begin
            busy_q    <= 1'b1;
            rows_q    <= rows_i;
            len_q     <= row_len_i;
            stride_q  <= row_stride_i;
            ld_addr_q <= in_base_i;
            st_addr_q <= out_base_i;
            lr_q      <= '0;
            sr_q      <= '0;
            sd_q      <= '0;
        end else begin
            if (ld_issue) begin
                lr_q      <= lr_q + CNT_W'(1);
                ld_addr_q <= ld_addr_q + stride_q;
            end
            if (st_issue) begin
                sr_q      <= sr_q + CNT_W'(1);
                st_addr_q <= st_addr_q + stride_q;
            end
            if (st_done) begin
                sd_q <= sd_inc;
            end
            if (tile_done) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Command outputs: fields are held from the address registers for the whole
    // tile so they are stable across any ready_start stall; zero when idle.
    always_comb begin
        in_ctrl_o  = '0;
        out_ctrl_o = '0;
        if (busy_q) begin
            in_ctrl_o.addressgen_ctrl.base_addr  = 32'(ld_addr_q);
            in_ctrl_o.addressgen_ctrl.tot_len    = 32'(len_q);
            in_ctrl_o.addressgen_ctrl.d0_len     = 32'(len_q);
            in_ctrl_o.addressgen_ctrl.d0_stride  = 32'(DATA_WIDTH / 8);
            out_ctrl_o.addressgen_ctrl.base_addr = 32'(st_addr_q);
            out_ctrl_o.addressgen_ctrl.tot_len   = 32'(len_q);
            out_ctrl_o.addressgen_ctrl.d0_len    = 32'(len_q);
            out_ctrl_o.addressgen_ctrl.d0_stride = 32'(DATA_WIDTH / 8);
        end
        in_ctrl_o.req_start  = ld_issue;
        out_ctrl_o.req_start = st_issue;
        busy_o      = busy_q;
        done_o      = tile_done;
        rows_done_o = sd_q[ROW_W-1:0];
    end

endmodule

// File: tb/tb_sfm_stream_sched.sv
module tb_sfm_stream_sched;
    import sfm_hci_pkg::*;

    localparam int MA = 2;

    typedef struct {
        logic [31:0] ib;
        logic [31:0] ob;
        logic [31:0] st;
        logic [15:0] rows;
        logic [15:0] len;
        int          lat;
        logic [31:0] ld_last;
        logic [31:0] st_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in_base = '0, out_base = '0, stride = '0;
    logic [15:0] rows = '0, len = '0;
    hci_streamer_ctrl_t  in_ctrl, out_ctrl;
    hci_streamer_flags_t in_flags, out_flags;
    logic        busy, done;
    logic [15:0] rows_done;

    // streamer responder knobs and state
    logic in_rdy = 1'b1, out_rdy = 1'b1, in_done_r = 1'b0, out_done_r = 1'b0;
    logic force_done = 1'b0, out_hold = 1'b0;
    int   in_lat = 5, out_lat = 5, in_cnt = 0, out_cnt = 0;

    assign in_flags  = {in_rdy, in_done_r | force_done};
    assign out_flags = {out_rdy, out_done_r | force_done};

    // monitor state
    int cyc = 0, n_vec = 0, n_err = 0;
    int n_ld, n_st, n_sd, n_done, ahead_viol, pulse_bad, ctrl_bad, done_bad;
    logic prev_in_req, prev_out_req, prev_done;
    logic [31:0] ld_q[$], st_q[$];
    int ld_cyc_q[$], sd_cyc_q[$];
    logic [31:0] exp_len;
    string tag = "init";
    vec_t vecs[5];

    always #5 clk = ~clk;

    sfm_stream_sched dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .start_i      (start),
        .in_base_i    (in_base),
        .out_base_i   (out_base),
        .row_stride_i (stride),
        .rows_i       (rows),
        .row_len_i    (len),
        .in_ctrl_o    (in_ctrl),
        .in_flags_i   (in_flags),
        .out_ctrl_o   (out_ctrl),
        .out_flags_i  (out_flags),
        .busy_o       (busy),
        .done_o       (done),
        .rows_done_o  (rows_done)
    );

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, nm, act, exp);
        end
    endtask

    function automatic int field_bad(hci_streamer_ctrl_t c, logic [31:0] l);
        hci_addressgen_ctrl_t a;
        a = c.addressgen_ctrl;
        if (a.tot_len != l || a.d0_len != l || a.d0_stride != 32'd4) return 1;
        if ({a.d1_len, a.d1_stride, a.d2_len, a.d2_stride, a.d3_stride, a.dim_enable_1h} != '0) return 1;
        return 0;
    endfunction

    task automatic reset_mon();
        n_ld = 0; n_st = 0; n_sd = 0; n_done = 0;
        ahead_viol = 0; pulse_bad = 0; ctrl_bad = 0; done_bad = 0;
        prev_in_req = 1'b0; prev_out_req = 1'b0; prev_done = 1'b0;
        ld_q.delete(); st_q.delete(); ld_cyc_q.delete(); sd_cyc_q.delete();
    endtask

    // Called at a negedge after inputs are set: observe just before the posedge,
    // then drive the responders' done flags at the next negedge.
    task automatic tick();
        logic nin, nout;
        #2;
        cyc++;
        if (out_done_r) begin
            n_sd++;
            sd_cyc_q.push_back(cyc);
        end
        if (in_ctrl.req_start) begin
            n_ld++;
            ld_q.push_back(in_ctrl.addressgen_ctrl.base_addr);
            ld_cyc_q.push_back(cyc);
            ctrl_bad += field_bad(in_ctrl, exp_len);
            if (prev_in_req) pulse_bad++;
        end
        if (out_ctrl.req_start) begin
            n_st++;
            st_q.push_back(out_ctrl.addressgen_ctrl.base_addr);
            ctrl_bad += field_bad(out_ctrl, exp_len);
            if (prev_out_req) pulse_bad++;
        end
        if (done) begin
            n_done++;
            if (!busy) done_bad++;
        end
        if (prev_done && busy) done_bad++;
        if (n_ld - n_sd > MA) ahead_viol++;
        prev_in_req  = in_ctrl.req_start;
        prev_out_req = out_ctrl.req_start;
        prev_done    = done;
        nin = 1'b0;
        if (in_cnt == 1) begin nin = 1'b1; in_cnt = 0; end
        else if (in_cnt > 1) in_cnt--;
        if (in_ctrl.req_start) in_cnt = in_lat;
        nout = 1'b0;
        if (out_cnt == 1 && !out_hold) begin nout = 1'b1; out_cnt = 0; end
        else if (out_cnt > 1) out_cnt--;
        if (out_ctrl.req_start) out_cnt = out_lat;
        @(negedge clk);
        in_done_r  = nin;
        out_done_r = nout;
    endtask

    task automatic start_tile(input logic [31:0] ib, ob, st, input logic [15:0] r, l);
        in_base = ib; out_base = ob; stride = st; rows = r; len = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int t;
        t = 0;
        while (n_done == 0 && t < budget) begin
            tick();
            t++;
        end
        check("done_within_budget", (n_done > 0), 1);
        repeat (3) tick();
    endtask

    task automatic check_tile(input logic [31:0] ib, ob, st, input logic [15:0] r);
        logic [31:0] e;
        check("n_loads", n_ld, r);
        check("n_stores", n_st, r);
        check("done_pulses", n_done, 1);
        check("rows_done", rows_done, r);
        check("busy_end", busy, 0);
        check("done_busy_timing", done_bad, 0);
        check("ctrl_fields", ctrl_bad, 0);
        check("one_cycle_req", pulse_bad, 0);
        check("run_ahead_bound", ahead_viol, 0);
        foreach (ld_q[k]) begin
            e = ib + 32'(k) * st;
            check("ld_addr", ld_q[k], e);
        end
        foreach (st_q[k]) begin
            e = ob + 32'(k) * st;
            check("st_addr", st_q[k], e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        //          in_base       out_base      stride      rows    len    lat  ld_last       st_last
        vecs[0] = '{32'h00001000, 32'h00002000, 32'h00000100, 16'd3, 16'd16, 5, 32'h00001200, 32'h00002200};
        vecs[1] = '{32'h00000000, 32'h00008000, 32'h00000040, 16'd1, 16'd8,  2, 32'h00000000, 32'h00008000};
        vecs[2] = '{32'hFFFFFF00, 32'h00000010, 32'h00000080, 16'd4, 16'd4,  1, 32'h00000080, 32'h00000190};
        vecs[3] = '{32'h00004000, 32'h00005000, 32'h00000020, 16'd5, 16'd32, 3, 32'h00004080, 32'h00005080};
        vecs[4] = '{32'h00006000, 32'h00007000, 32'h00000010, 16'd0, 16'd4,  2, 32'h00000000, 32'h00000000};

        @(negedge clk);

        // reset held with flags and start toggling
        tag = "reset";
        reset_mon();
        exp_len = '0;
        start = 1'b1; in_base = 32'h1234; rows = 16'd5; len = 16'd3;
        for (int i = 0; i < 6; i++) begin
            force_done = i[0];
            in_rdy     = ~i[0];
            out_rdy    = i[0];
            tick();
        end
        check("busy", busy, 0);
        check("done", done, 0);
        check("rows_done", rows_done, 0);
        check("in_ctrl_zero", (in_ctrl != '0), 0);
        check("out_ctrl_zero", (out_ctrl != '0), 0);
        check("no_activity", n_ld + n_st + n_done, 0);
        start = 1'b0; force_done = 1'b0; in_rdy = 1'b1; out_rdy = 1'b1;
        rst_n = 1'b1;
        tick();
        tick();

        // table-driven tiles
        for (int i = 0; i < 5; i++) begin
            tag = $sformatf("vec%0d", i);
            reset_mon();
            exp_len = 32'(vecs[i].len);
            in_lat  = vecs[i].lat;
            out_lat = vecs[i].lat;
            start_tile(vecs[i].ib, vecs[i].ob, vecs[i].st, vecs[i].rows, vecs[i].len);
            check("busy_after_start", busy, 1);
            wait_done(400);
            check_tile(vecs[i].ib, vecs[i].ob, vecs[i].st, vecs[i].rows);
            if (vecs[i].rows != 0) begin
                check("ld_last", ld_q[$], vecs[i].ld_last);
                check("st_last", st_q[$], vecs[i].st_last);
            end
        end

        // run-ahead bound with store done withheld
        tag = "run_ahead";
        reset_mon();
        exp_len = 32'd8; in_lat = 2; out_lat = 2; out_hold = 1'b1;
        start_tile(32'h100, 32'h200, 32'h10, 16'd4, 16'd8);
        repeat (40) tick();
        check("loads_while_held", n_ld, 2);
        check("stores_while_held", n_st, 1);
        out_hold = 1'b0;
        wait_done(400);
        check_tile(32'h100, 32'h200, 32'h10, 16'd4);
        check("third_load_cycle", ld_cyc_q[2], sd_cyc_q[0] + 1);

        // load ready_start held low for 10 cycles
        tag = "backpressure";
        reset_mon();
        exp_len = 32'd5; in_lat = 3; out_lat = 3; in_rdy = 1'b0;
        start_tile(32'hA000, 32'hB000, 32'h8, 16'd2, 16'd5);
        repeat (10) tick();
        check("no_load_req", n_ld, 0);
        check("no_store_req", n_st, 0);
        check("addr_held", in_ctrl.addressgen_ctrl.base_addr, 32'hA000);
        in_rdy = 1'b1;
        tick();
        check("req_on_rise", n_ld, 1);
        tick();
        check("req_one_cycle", n_ld, 1);
        wait_done(400);
        check_tile(32'hA000, 32'hB000, 32'h8, 16'd2);

        // start_i pulsed mid-tile with different cfg
        tag = "start_busy";
        reset_mon();
        exp_len = 32'd7; in_lat = 4; out_lat = 4;
        start_tile(32'h3000, 32'h3800, 32'h10, 16'd2, 16'd7);
        repeat (4) tick();
        start_tile(32'h9000, 32'h9800, 32'h40, 16'd7, 16'd9);
        wait_done(400);
        check_tile(32'h3000, 32'h3800, 32'h10, 16'd2);

        // clear after one row, then a fresh tile
        tag = "abort";
        reset_mon();
        exp_len = 32'd16; in_lat = 5; out_lat = 5;
        start_tile(32'h1000, 32'h2000, 32'h100, 16'd3, 16'd16);
        t = 0;
        while (rows_done == 0 && t < 200) begin
            tick();
            t++;
        end
        check("one_row_before_clear", rows_done, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_cnt = 0; out_cnt = 0; in_done_r = 1'b0; out_done_r = 1'b0;
        check("busy_after_clear", busy, 0);
        check("rows_done_after_clear", rows_done, 0);
        check("in_ctrl_after_clear", (in_ctrl != '0), 0);
        check("out_ctrl_after_clear", (out_ctrl != '0), 0);
        reset_mon();
        repeat (5) tick();
        check("no_stale_done", n_done, 0);
        exp_len = 32'd4;
        start_tile(32'h7000, 32'h7800, 32'h40, 16'd2, 16'd4);
        wait_done(400);
        check_tile(32'h7000, 32'h7800, 32'h40, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sfm_stream_sched.md
Name: sfm_stream_sched

Overview:
- Row scheduler for the softmax streamer's main load/store pair.
- Takes a tile descriptor: base addresses, row count, row length and row stride.
- Issues one load command and one store command per row to the streamer's input and output hci_streamer_ctrl_t ports.
- Bounds how far loads may run ahead of completed stores, and signals tile completion to the controller FSM.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- ROW_W, 16, width of the row counters and rows_i.
- LEN_W, 16, width of row_len_i (row length in streamer words).
- MAX_AHEAD, 2, max rows whose load is issued but whose store is not yet done (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear; same effect as reset.
- start_i  in  1  one-cycle tile start; sampled only when busy_o=0.
- in_base_i  in  ADDR_WIDTH  byte address of row 0 input.
- out_base_i  in  ADDR_WIDTH  byte address of row 0 output.
- row_stride_i  in  ADDR_WIDTH  byte distance between rows; same for input and output.
- rows_i  in  ROW_W  number of rows.
- row_len_i  in  LEN_W  words per row.
- in_ctrl_o  out  hci_streamer_ctrl_t  load stream command.
- in_flags_i  in  hci_streamer_flags_t  load stream flags; uses ready_start and done.
- out_ctrl_o  out  hci_streamer_ctrl_t  store stream command.
- out_flags_i  in  hci_streamer_flags_t  store stream flags.
- busy_o  out  1  tile in progress.
- done_o  out  1  one-cycle pulse when the last store completes.
- rows_done_o  out  ROW_W  count of completed stores.

Behaviour:
- Reset/clear:
  - All outputs 0; both FSMs return to IDLE.
  - Counters cleared.
  - Reset mid-tile abandons the tile with no done_o.
- Start:
  - start_i with busy_o=0 latches all cfg inputs.
  - busy_o goes 1 next cycle.
  - lr (loads issued), sr (stores issued), sd (stores done) = 0.
  - Load address register = in_base; store address register = out_base.
  - start_i while busy_o=1 is ignored.
  - rows_i=0: busy_o=1 for one cycle, done_o pulses the same cycle busy_o falls, no req_start issued.
- Command fields:
  - req_start.
  - addressgen_ctrl.base_addr = current address register.
  - addressgen_ctrl.tot_len = row_len.
  - addressgen_ctrl.d0_len = row_len.
  - addressgen_ctrl.d0_stride = DATA_WIDTH/8.
  - All other fields 0.
  - Fields are stable whenever req_start=1.
- Load FSM (L_IDLE, L_ISSUE, L_WAIT):
  - L_IDLE -> L_ISSUE on accepted start with rows>0.
  - L_ISSUE:
    - Asserts in_ctrl_o.req_start for exactly one cycle when in_flags_i.ready_start=1 and (lr - sd) < MAX_AHEAD.
    - That cycle: lr++, load address += row_stride (wraps mod 2^ADDR_WIDTH).
    - Then -> L_WAIT.
  - L_WAIT -> L_ISSUE on in_flags_i.done if lr<rows, else -> L_IDLE.
- Store FSM (S_IDLE, S_ISSUE, S_WAIT):
  - S_ISSUE:
    - Asserts out_ctrl_o.req_start one cycle when out_flags_i.ready_start=1 and sr<lr.
    - That cycle: sr++, store address += row_stride.
    - Then -> S_WAIT.
  - S_WAIT, on out_flags_i.done:
    - sd++, rows_done_o=sd.
    - If sd reaches rows: -> S_IDLE, done_o=1 that cycle, busy_o=0 next cycle.
    - Else -> S_ISSUE.
- Same-cycle issue:
  - A load issue and a store issue may occur in the same cycle.
  - A store issue uses lr before that cycle's increment, so a store never issues the same cycle as its own row's load.
- Same-cycle done and issue:
  - A store done coinciding with a load issue check uses sd before increment; the load issues next cycle at the earliest.
- Spurious flags:
  - done flags in IDLE/ISSUE states are ignored.
- Counter widths:
  - lr, sr and sd are ROW_W+1 bits wide, so rows = 2^ROW_W - 1 does not overflow.

Test Plan:
- Reset: hold rst_ni=0, toggle flags -> all outputs 0, busy_o=0, no req_start.
- Basic tile:
  - Stimulus: in_base=0x1000, out_base=0x2000, stride=0x100, rows=3, len=16; ready_start always 1; done 5 cycles after each req.
  - Required: load bases 0x1000, 0x1100, 0x1200; store bases 0x2000, 0x2100, 0x2200; tot_len=16; done_o single pulse after the 3rd store done; rows_done_o=3.
- Run-ahead bound:
  - Stimulus: MAX_AHEAD=2, rows=4, out done withheld.
  - Required: exactly 2 load req_start; the 3rd load issues the cycle after the 1st store done.
- Ready_start back-pressure:
  - Stimulus: in ready_start held 0 for 10 cycles.
  - Required: no req_start until it rises; the request is then a one-cycle pulse with a stable address.
- rows=0, then start while busy:
  - Stimulus: start with rows=0; then start a tile and pulse start_i again mid-tile.
  - Required: the rows=0 start gives a done_o pulse with no requests; the mid-tile start is ignored and cfg is unchanged.
- Mid-tile abort:
  - Stimulus: clear_i after 1 row done, then a new start with rows=2.
  - Required: outputs 0 after the clear; the new tile restarts from its base addresses; no stale done_o.
